// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle for sync_fifo_flex.
// The producer/consumer side uses the master modport; the FIFO uses the slave modport.
interface sync_fifo_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic                  w_inc;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  r_inc;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [AW:0]           count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_inc, wr_data, r_inc, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  w_inc, wr_data, r_inc, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/almost-empty
// thresholds, optional first-word-fall-through read, and sticky error flags.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sync_fifo_flex_if.slave       bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AfLvl  = AF_LEVEL[AW:0];
  localparam logic [AW:0] AeLvl  = AE_LEVEL[AW:0];

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [AW:0] wPtr_q, wPtr_d;
  logic [AW:0] rPtr_q, rPtr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        almostFull_q, almostFull_d;
  logic        almostEmpty_q, almostEmpty_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic        wrEn;
  logic        rdEn;

  // Accept decisions use only registered flags, so a full FIFO never takes a
  // write through a same-cycle read (and likewise for reads while empty).
  assign wrEn = !rst_i && bus.w_inc && !full_q;
  assign rdEn = !rst_i && bus.r_inc && !empty_q;

  // Next pointers, post-edge status and sticky error flags.
  always_comb begin
    wPtr_d        = wPtr_q;
    rPtr_d        = rPtr_q;
    count_d       = count_q;
    full_d        = full_q;
    empty_d       = empty_q;
    almostFull_d  = almostFull_q;
    almostEmpty_d = almostEmpty_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;

    if (wrEn) wPtr_d = wPtr_q + PtrOne;
    if (rdEn) rPtr_d = rPtr_q + PtrOne;

    count_d       = wPtr_d - rPtr_d;
    full_d        = (wPtr_d[AW-1:0] == rPtr_d[AW-1:0]) && (wPtr_d[AW] != rPtr_d[AW]);
    empty_d       = (wPtr_d == rPtr_d);
    almostFull_d  = (count_d >= AfLvl);
    almostEmpty_d = (count_d <= AeLvl);

    if (bus.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.w_inc && full_q)  overflow_d  = 1'b1;
    if (bus.r_inc && empty_q) underflow_d = 1'b1;
  end

  // State register; reset discards contents by zeroing both pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wPtr_q        <= '0;
      rPtr_q        <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almostFull_q  <= 1'b0;
      almostEmpty_q <= 1'b1;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wPtr_q        <= wPtr_d;
      rPtr_q        <= rPtr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      almostFull_q  <= almostFull_d;
      almostEmpty_q <= almostEmpty_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  // Storage array, deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wrEn) mem[wPtr_q[AW-1:0]] <= bus.wr_data;
  end

  generate
    if (FWFT) begin : gFwft
      // Head word is always visible; a pop simply advances the read pointer.
      assign bus.rd_data  = mem[rPtr_q[AW-1:0]];
      assign bus.rd_valid = !empty_q;
    end else begin : gStd
      logic [DATA_WIDTH-1:0] rdData_q;
      logic                  rdValid_q;

      // Registered read: data captured on a pop and held, valid pulses once.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rdData_q  <= '0;
          rdValid_q <= 1'b0;
        end else begin
          rdValid_q <= rdEn;
          if (rdEn) rdData_q <= mem[rPtr_q[AW-1:0]];
        end
      end

      assign bus.rd_data  = rdData_q;
      assign bus.rd_valid = rdValid_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almostFull_q;
  assign bus.almost_empty = almostEmpty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: a standard-read instance (busA) and a
// fall-through instance (busB), both depth 4 with AF=3 and AE=1.
module tb_sync_fifo_flex;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] expQ [$];
  logic [7:0] expWord;

  sync_fifo_flex_if #(.DATA_WIDTH(8), .MEM_DEPTH(4)) busA ();
  sync_fifo_flex_if #(.DATA_WIDTH(8), .MEM_DEPTH(4)) busB ();

  sync_fifo_flex #(.DATA_WIDTH(8), .MEM_DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b0))
    dutA (.clk_i(clk), .rst_i(rst), .bus(busA.slave));
  sync_fifo_flex #(.DATA_WIDTH(8), .MEM_DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b1))
    dutB (.clk_i(clk), .rst_i(rst), .bus(busB.slave));

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive instance A's inputs, then let one rising edge pass and settle.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic c);
    busA.w_inc   = w;
    busA.wr_data = d;
    busA.r_inc   = r;
    busA.clr_err = c;
    @(posedge clk);
    #1;
  endtask

  // Directed sequence covering fill, errors, wrap, fall-through and reset.
  initial begin
    busA.w_inc = 1'b0; busA.wr_data = '0; busA.r_inc = 1'b0; busA.clr_err = 1'b0;
    busB.w_inc = 1'b0; busB.wr_data = '0; busB.r_inc = 1'b0; busB.clr_err = 1'b0;

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("rst_count", busA.count, 0);
    checkOutput("rst_empty", busA.empty, 1);
    checkOutput("rst_full", busA.full, 0);
    checkOutput("rst_ae", busA.almost_empty, 1);
    checkOutput("rst_af", busA.almost_full, 0);
    checkOutput("rst_rdvalid", busA.rd_valid, 0);
    checkOutput("rst_rddata", busA.rd_data, 0);
    checkOutput("rst_ovf", busA.overflow, 0);
    checkOutput("rst_udf", busA.underflow, 0);
    checkOutput("rstB_rdvalid", busB.rd_valid, 0);

    // Fill to full and watch the thresholds move
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    checkOutput("w1_count", busA.count, 1);
    checkOutput("w1_empty", busA.empty, 0);
    checkOutput("w1_ae", busA.almost_empty, 1);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    checkOutput("w2_count", busA.count, 2);
    checkOutput("w2_ae", busA.almost_empty, 0);
    checkOutput("w2_af", busA.almost_full, 0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    checkOutput("w3_count", busA.count, 3);
    checkOutput("w3_af", busA.almost_full, 1);
    checkOutput("w3_full", busA.full, 0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    checkOutput("w4_count", busA.count, 4);
    checkOutput("w4_full", busA.full, 1);

    // Overflow and its clear, including clear colliding with a new overflow
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("ovf_set", busA.overflow, 1);
    checkOutput("ovf_count", busA.count, 4);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_clr", busA.overflow, 0);
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b1);
    checkOutput("ovf_clr_vs_set", busA.overflow, 1);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkOutput("full_wr_rd_drop_count", busA.count, 3);
    checkOutput("full_wr_rd_data", busA.rd_data, 8'h11);
    checkOutput("full_wr_rd_valid", busA.rd_valid, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_clr2", busA.overflow, 0);
    checkOutput("idle_rdvalid", busA.rd_valid, 0);

    // Drain the remaining three words in order
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("r2_data", busA.rd_data, 8'h22);
    checkOutput("r2_valid", busA.rd_valid, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("r3_data", busA.rd_data, 8'h33);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("r4_data", busA.rd_data, 8'h44);
    checkOutput("r4_empty", busA.empty, 1);
    checkOutput("r4_count", busA.count, 0);

    // Underflow while empty, including a write in the same cycle
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("udf_set", busA.underflow, 1);
    checkOutput("udf_rdvalid", busA.rd_valid, 0);
    checkOutput("udf_rddata_hold", busA.rd_data, 8'h44);
    checkOutput("udf_count", busA.count, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("udf_clr", busA.underflow, 0);

    // Steady state at COUNT=2 with simultaneous push/pop across pointer wrap
    expQ.delete();
    applyStimulus(1'b1, 8'hA0, 1'b1, 1'b0);
    checkOutput("empty_wr_rd_count", busA.count, 1);
    checkOutput("empty_wr_rd_udf", busA.underflow, 1);
    checkOutput("empty_wr_rd_valid", busA.rd_valid, 0);
    expQ.push_back(8'hA0);
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b1);
    expQ.push_back(8'hA1);
    checkOutput("pre_wrap_count", busA.count, 2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0);
      expQ.push_back(8'hB0 + 8'(i));
      expWord = expQ.pop_front();
      checkOutput($sformatf("wrap_data_%0d", i), busA.rd_data, expWord);
      checkOutput($sformatf("wrap_count_%0d", i), busA.count, 2);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      expWord = expQ.pop_front();
      checkOutput($sformatf("wrap_drain_%0d", i), busA.rd_data, expWord);
    end
    checkOutput("wrap_empty", busA.empty, 1);

    // Fall-through instance: head visible without a pop
    busB.w_inc = 1'b1; busB.wr_data = 8'hA5;
    @(posedge clk); #1;
    busB.w_inc = 1'b0; busB.wr_data = 8'h00;
    checkOutput("fwft_valid", busB.rd_valid, 1);
    checkOutput("fwft_data", busB.rd_data, 8'hA5);
    @(posedge clk); #1;
    checkOutput("fwft_hold_valid", busB.rd_valid, 1);
    checkOutput("fwft_hold_data", busB.rd_data, 8'hA5);
    busB.r_inc = 1'b1;
    @(posedge clk); #1;
    checkOutput("fwft_pop_empty", busB.empty, 1);
    checkOutput("fwft_pop_valid", busB.rd_valid, 0);
    @(posedge clk); #1;
    busB.r_inc = 1'b0;
    checkOutput("fwft_udf", busB.underflow, 1);

    // Mid-operation reset with a write request held high
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    checkOutput("prerst_count", busA.count, 3);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    rst = 1'b0;
    checkOutput("midrst_count", busA.count, 0);
    checkOutput("midrst_empty", busA.empty, 1);
    checkOutput("midrst_ae", busA.almost_empty, 1);
    checkOutput("midrst_af", busA.almost_full, 0);
    checkOutput("midrst_rddata", busA.rd_data, 0);
    checkOutput("midrst_rdvalid", busA.rd_valid, 0);
    checkOutput("midrst_udf_B", busB.underflow, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("postrst_count", busA.count, 0);
    checkOutput("postrst_empty", busA.empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
